// File: rtl/sparse_weight_loader.sv
// sparse_weight_loader: streams 2:4-compressed weight entries from memory and packs them into
// NUM_PE-row tiles for sparse_core. Optional index-order check: define SPARSE_LDR_IDX_CHECK_EN.
package sparse_pkg;
  typedef struct packed {
    logic signed [7:0] val_0;
    logic signed [7:0] val_1;
    logic        [1:0] idx_0;
    logic        [1:0] idx_1;
  } sparse_packet_t;
endpackage

module sparse_weight_loader #(
  parameter int NUM_PE = 4,
  parameter int ADDR_W = 10,
  parameter int TILE_W = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [ADDR_W-1:0]                       base_addr,
  input  logic [TILE_W-1:0]                       num_tiles,
  output logic                                    mem_rd_en,
  output logic [ADDR_W-1:0]                       mem_addr,
  input  logic [9:0]                              mem_rdata,
  output sparse_pkg::sparse_packet_t [0:NUM_PE-1] w_rows,
  output logic                                    w_valid,
  input  logic                                    w_ready,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    idx_err
);

  localparam int ENTRIES = 2 * NUM_PE;
  localparam int ROW_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int K_W     = ROW_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       state;
  logic [K_W-1:0]   rd_cnt;
  logic [TILE_W-1:0] tile;
  logic [TILE_W-1:0] num_tiles_q;
  logic             cap_vld_p1;
  logic [K_W-1:0]   cap_k_p1;
  logic [ROW_W-1:0] cap_row_p1;

  function automatic logic signed [7:0] entry_val(input logic [9:0] entry);
    return $signed(entry[7:0]);
  endfunction

  function automatic logic [1:0] entry_idx(input logic [9:0] entry);
    return entry[9:8];
  endfunction

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign cap_row_p1 = cap_k_p1[K_W-1:1];

  // p0: read issue and control; the entry number rides one cycle behind the read
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      rd_cnt      <= '0;
      tile        <= '0;
      num_tiles_q <= '0;
      cap_vld_p1  <= 1'b0;
      cap_k_p1    <= '0;
      w_valid     <= 1'b0;
    end else begin
      cap_vld_p1 <= mem_rd_en;
      cap_k_p1   <= rd_cnt;
      case (state)
        S_IDLE: begin
          if (start) begin
            tile        <= '0;
            num_tiles_q <= num_tiles;
            if (num_tiles == '0) begin
              state <= S_DONE;
            end else begin
              state     <= S_FETCH;
              mem_rd_en <= 1'b1;
              mem_addr  <= base_addr;
              rd_cnt    <= '0;
            end
          end
        end
        S_FETCH: begin
          if (mem_rd_en) begin
            if (rd_cnt == K_W'(ENTRIES - 1)) begin
              mem_rd_en <= 1'b0;
            end else begin
              rd_cnt   <= rd_cnt + K_W'(1);
              mem_addr <= mem_addr + ADDR_W'(1);
            end
          end
          if (cap_vld_p1 && (cap_k_p1 == K_W'(ENTRIES - 1))) begin
            state   <= S_PRESENT;
            w_valid <= 1'b1;
          end
        end
        S_PRESENT: begin
          if (w_ready) begin
            w_valid <= 1'b0;
            if (tile == num_tiles_q - TILE_W'(1)) begin
              state <= S_DONE;
            end else begin
              // tiles are contiguous, so the next tile starts one past the last read
              tile      <= tile + TILE_W'(1);
              state     <= S_FETCH;
              mem_rd_en <= 1'b1;
              mem_addr  <= mem_addr + ADDR_W'(1);
              rd_cnt    <= '0;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // p1: capture returning entry into its row slot
  always_ff @(posedge clk) begin
    if (rst) begin
      w_rows <= '0;
    end else if (cap_vld_p1) begin
      if (cap_k_p1[0]) begin
        w_rows[cap_row_p1].val_1 <= entry_val(mem_rdata);
        w_rows[cap_row_p1].idx_1 <= entry_idx(mem_rdata);
      end else begin
        w_rows[cap_row_p1].val_0 <= entry_val(mem_rdata);
        w_rows[cap_row_p1].idx_0 <= entry_idx(mem_rdata);
      end
    end
  end

`ifdef SPARSE_LDR_IDX_CHECK_EN
  function automatic logic pair_bad(input logic [1:0] idx_0, input logic [1:0] idx_1);
    return idx_1 <= idx_0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_err <= 1'b0;
    end else if (cap_vld_p1 && cap_k_p1[0] &&
                 pair_bad(w_rows[cap_row_p1].idx_0, entry_idx(mem_rdata))) begin
      idx_err <= 1'b1;
    end
  end
`else
  assign idx_err = 1'b0;
`endif

endmodule

// File: tb/tb_sparse_weight_loader.sv
// Bench for sparse_weight_loader: directed and randomized loads against a tile-level model
// of the memory layout, schedule and index-pair rule.
module tb_sparse_weight_loader;
  import sparse_pkg::*;

  localparam int NUM_PE = 4;
  localparam int ADDR_W = 10;
  localparam int TILE_W = 8;
  localparam int ENT    = 2 * NUM_PE;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          start;
  logic [ADDR_W-1:0]             base_addr;
  logic [TILE_W-1:0]             num_tiles;
  logic                          mem_rd_en;
  logic [ADDR_W-1:0]             mem_addr;
  logic [9:0]                    mem_rdata;
  sparse_packet_t [0:NUM_PE-1]   w_rows;
  logic                          w_valid;
  logic                          w_ready;
  logic                          busy;
  logic                          done;
  logic                          idx_err;

  logic [9:0] mem [0:(1<<ADDR_W)-1];
  int         tests = 0;
  int         fails = 0;
  logic       exp_err = 1'b0;

  always #5 clk = ~clk;

  sparse_weight_loader #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .TILE_W(TILE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_tiles(num_tiles),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .w_rows(w_rows), .w_valid(w_valid), .w_ready(w_ready),
    .busy(busy), .done(done), .idx_err(idx_err)
  );

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic sparse_packet_t exp_pkt(input logic [ADDR_W-1:0] a);
    sparse_packet_t p;
    logic [9:0] e0, e1;
    e0 = mem[a];
    e1 = mem[ADDR_W'(a + 1)];
    p.val_0 = e0[7:0];
    p.val_1 = e1[7:0];
    p.idx_0 = e0[9:8];
    p.idx_1 = e1[9:8];
    return p;
  endfunction

  task automatic chk_reset_state();
    chk("rst_valid", 64'(w_valid), 64'(0));
    chk("rst_rd_en", 64'(mem_rd_en), 64'(0));
    chk("rst_addr", 64'(mem_addr), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_idx_err", 64'(idx_err), 64'(0));
    for (int r = 0; r < NUM_PE; r++) chk("rst_rows", 64'(w_rows[r]), 64'(0));
  endtask

  // One complete load: checks every cycle from the start edge through done.
  task automatic do_load(input logic [ADDR_W-1:0] b, input logic [TILE_W-1:0] nt,
                         input int stall_lo, input int stall_hi, input bit poke);
    logic [ADDR_W-1:0] ta;
    sparse_packet_t    er [NUM_PE];
    int                stall;
    @(negedge clk);
    start = 1'b1; base_addr = b; num_tiles = nt; w_ready = 1'b0;
    step();
    start = 1'b0;
    if (nt == 0) begin
      chk("zero_done", 64'(done), 64'(1));
      chk("zero_rd", 64'(mem_rd_en), 64'(0));
      chk("zero_busy", 64'(busy), 64'(1));
      step();
      chk("zero_done_drop", 64'(done), 64'(0));
      chk("zero_idle", 64'(busy), 64'(0));
      chk("zero_no_rd", 64'(mem_rd_en), 64'(0));
      return;
    end
    for (int t = 0; t < int'(nt); t++) begin
      ta = b + ADDR_W'(t * ENT);
      for (int k = 0; k < ENT; k++) begin
        chk("rd_en", 64'(mem_rd_en), 64'(1));
        chk("addr", 64'(mem_addr), 64'(ADDR_W'(ta + k)));
        chk("valid_fetch", 64'(w_valid), 64'(0));
        chk("busy_fetch", 64'(busy), 64'(1));
        if (poke && k == 3) begin
          start = 1'b1; base_addr = ~b; num_tiles = 8'd7;
        end else begin
          start = 1'b0; base_addr = b; num_tiles = nt;
        end
        w_ready = 1'($urandom_range(0, 1));
        step();
      end
      start = 1'b0; base_addr = b; num_tiles = nt;
      chk("rd_stop", 64'(mem_rd_en), 64'(0));
      chk("valid_early", 64'(w_valid), 64'(0));
      w_ready = 1'($urandom_range(0, 1));
      step();
      chk("valid_rise", 64'(w_valid), 64'(1));
      for (int r = 0; r < NUM_PE; r++) begin
        er[r] = exp_pkt(ADDR_W'(ta + 2 * r));
`ifdef SPARSE_LDR_IDX_CHECK_EN
        if (er[r].idx_1 <= er[r].idx_0) exp_err = 1'b1;
`endif
        chk("row", 64'(w_rows[r]), 64'(er[r]));
      end
      chk("idx_err", 64'(idx_err), 64'(exp_err));
      stall = $urandom_range(stall_hi, stall_lo);
      for (int s = 0; s < stall; s++) begin
        w_ready = 1'b0;
        step();
        chk("valid_hold", 64'(w_valid), 64'(1));
        chk("no_rd_stall", 64'(mem_rd_en), 64'(0));
        for (int r = 0; r < NUM_PE; r++) chk("row_hold", 64'(w_rows[r]), 64'(er[r]));
      end
      w_ready = 1'b1;
      step();
      w_ready = 1'b0;
      chk("valid_drop", 64'(w_valid), 64'(0));
      if (t == int'(nt) - 1) begin
        chk("done_pulse", 64'(done), 64'(1));
        chk("busy_at_done", 64'(busy), 64'(1));
        chk("no_rd_done", 64'(mem_rd_en), 64'(0));
        step();
        chk("done_drop", 64'(done), 64'(0));
        chk("busy_drop", 64'(busy), 64'(0));
        for (int r = 0; r < NUM_PE; r++) chk("row_keep", 64'(w_rows[r]), 64'(er[r]));
      end else begin
        chk("done_early", 64'(done), 64'(0));
      end
    end
  endtask

  initial begin
    int psum;
    int exp_psum [1:3];
    exp_psum[1] = 240; exp_psum[2] = -100; exp_psum[3] = -360;

    rst = 1'b1; start = 1'b0; base_addr = '0; num_tiles = '0; w_ready = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 10'($urandom);
    repeat (2) step();
    chk_reset_state();
    rst = 1'b0;
    step();

    // Single tile with known contents
    mem[0] = {2'd0, 8'h0B}; mem[1] = {2'd2, 8'h0A};
    mem[2] = {2'd1, 8'h10}; mem[3] = {2'd3, 8'h08};
    mem[4] = {2'd0, 8'hFB}; mem[5] = {2'd1, 8'hFB};
    mem[6] = {2'd2, 8'hED}; mem[7] = {2'd3, 8'hEF};
    do_load(10'd0, 8'd1, 0, 0, 1'b0);
    chk("row1_const", 64'(w_rows[1]), 64'({8'd16, 8'd8, 2'd1, 2'd3}));
    chk("row3_const", 64'(w_rows[3]), 64'({8'hED, 8'hEF, 2'd2, 2'd3}));
    for (int r = 1; r <= 3; r++) begin
      psum = 10 * (int'(w_rows[r].val_0) + int'(w_rows[r].val_1));
      chk("psum", 64'(psum), 64'(exp_psum[r]));
    end

    // Back-pressure, wrap-around multi-tile, zero tiles, start during fetch
    do_load(10'd40, 8'd1, 5, 5, 1'b0);
    do_load(10'd1020, 8'd3, 0, 3, 1'b0);
    do_load(10'd77, 8'd0, 0, 0, 1'b0);
    do_load(10'd100, 8'd2, 0, 2, 1'b1);

    // Reset in the middle of a fetch
    @(negedge clk);
    start = 1'b1; base_addr = 10'd500; num_tiles = 8'd2;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    exp_err = 1'b0;
    chk_reset_state();
    rst = 1'b0;
    repeat (2) step();
    chk("post_rst_valid", 64'(w_valid), 64'(0));
    chk("post_rst_rd", 64'(mem_rd_en), 64'(0));
    for (int r = 0; r < NUM_PE; r++) chk("post_rst_rows", 64'(w_rows[r]), 64'(0));
    do_load(10'd600, 8'd1, 0, 2, 1'b0);

    // Bad index pair in the first tile, valid pairs in the second
    rst = 1'b1;
    step();
    exp_err = 1'b0;
    rst = 1'b0;
    for (int i = 200; i < 216; i++)
      mem[i] = {((i % 2) == 0) ? 2'd1 : 2'd2, 8'($urandom)};
    mem[200] = {2'd2, 8'h05};
    mem[201] = {2'd1, 8'hF0};
    do_load(10'd200, 8'd2, 0, 1, 1'b0);
    chk("idx_err_final", 64'(idx_err), 64'(exp_err));

    // Randomized loads
    for (int n = 0; n < 5; n++)
      do_load(10'($urandom), 8'($urandom_range(1, 3)), 0, 4, 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
